// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman keyboard path: receiver states,
// PS/2 scan codes and the arrow-key to direction lookup.
package pacman_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

   // Direction vector ordering is {up, down, left, right}; non-arrow codes map to zero.
   function automatic logic [3:0] arrow_dir(input logic [7:0] code);
      logic [3:0] dir;
      dir = 4'b0000;
      case (code)
         KEY_UP:    dir = 4'b1000;
         KEY_DOWN:  dir = 4'b0100;
         KEY_LEFT:  dir = 4'b0010;
         KEY_RIGHT: dir = 4'b0001;
         default:   dir = 4'b0000;
      endcase
      return dir;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 lines plus a one-cycle pulse on
// each falling edge of the synchronized keyboard clock.
module ps2_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_ps2_clk,
   input  logic i_ps2_dat,
   output logic o_ps2_dat,
   output logic o_ps2_fall
);

   logic [1:0] r_clk_sync;
   logic [1:0] r_dat_sync;
   logic       r_clk_prev;

   // NOTE: synchronizers reset to 1, the idle level of the PS/2 bus, so that
   // leaving reset never manufactures a false falling edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
         r_clk_prev <= r_clk_sync[1];
      end
   end

   assign o_ps2_dat  = r_dat_sync[1];
   assign o_ps2_fall = r_clk_prev & ~r_clk_sync[1];

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver turning extended arrow make/break codes into level
// direction requests. Define PS2_TIMEOUT_EN to build the frame watchdog.
module ps2_arrow_decoder
   import pacman_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [7:0] scan_code,
   output logic       make_break,
   output logic       code_valid,
   output logic       frame_err
);

   logic       w_ps2_dat;
   logic       w_ps2_fall;
   rx_state_e  r_state;
   rx_state_e  w_next_state;
   logic [7:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic       r_par;
   logic       r_ext;
   logic       r_brk;
   logic [3:0] r_dir;
   logic [7:0] r_scan_code;
   logic       r_make_break;
   logic       r_code_valid;
   logic       r_frame_err;
   logic       w_timeout;
   logic       w_stop_edge;
   logic       w_accept;
   logic       w_reject;
   logic       w_key_done;
   logic [3:0] w_arrow;

   ps2_sync_edge u_sync (
      .i_clk      (CLOCK_50),
      .i_rst_n    (reset_n),
      .i_ps2_clk  (PS2_CLK),
      .i_ps2_dat  (PS2_DAT),
      .o_ps2_dat  (w_ps2_dat),
      .o_ps2_fall (w_ps2_fall)
   );

`ifdef PS2_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)
         r_to_cnt <= '0;
      else if (w_ps2_fall || r_state == ST_IDLE)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + TO_W'(1);
   end

   assign w_timeout = (r_state != ST_IDLE) && !w_ps2_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // NOTE: state and datapath flops use non-blocking assignments so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   // NOTE: the default assignment up front keeps this block latch-free.
   always_comb begin
      w_next_state = r_state;
      if (w_timeout) begin
         w_next_state = ST_IDLE;
      end else if (w_ps2_fall) begin
         case (r_state)
            ST_IDLE:   if (!w_ps2_dat) w_next_state = ST_DATA;
            ST_DATA:   if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
            ST_PARITY: w_next_state = ST_STOP;
            ST_STOP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_stop_edge = w_ps2_fall && (r_state == ST_STOP);
      w_accept    = w_stop_edge && (^{r_shift, r_par}) && w_ps2_dat;
      w_reject    = w_stop_edge && !((^{r_shift, r_par}) && w_ps2_dat);
      w_key_done  = w_accept && (r_shift != PS2_EXT) && (r_shift != PS2_BRK);
      w_arrow     = r_ext ? arrow_dir(r_shift) : 4'b0000;
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
      end else if (w_ps2_fall && !w_timeout) begin
         case (r_state)
            ST_IDLE: begin
               r_shift   <= '0;
               r_bit_cnt <= '0;
            end
            ST_DATA: begin
               r_shift   <= {w_ps2_dat, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            ST_PARITY: r_par <= w_ps2_dat;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_dir        <= '0;
         r_scan_code  <= '0;
         r_make_break <= 1'b0;
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_code_valid <= w_key_done;
         r_frame_err  <= w_reject || w_timeout;
         if (w_reject || w_timeout || w_key_done) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
         end else if (w_accept && r_shift == PS2_EXT) begin
            r_ext <= 1'b1;
         end else if (w_accept && r_shift == PS2_BRK) begin
            r_brk <= 1'b1;
         end
         if (w_key_done) begin
            r_scan_code  <= r_shift;
            r_make_break <= ~r_brk;
            // A break only releases the direction it names; last press wins on make.
            if (w_arrow != 4'b0000) begin
               if (!r_brk)               r_dir <= w_arrow;
               else if (r_dir == w_arrow) r_dir <= '0;
            end
         end
      end
   end

   assign {up, down, left, right} = r_dir;
   assign scan_code  = r_scan_code;
   assign make_break = r_make_break;
   assign code_valid = r_code_valid;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: byte-level key model plus an every-cycle
// comparator; the watchdog scenario runs when PS2_TIMEOUT_EN is defined.
module tb_ps2_arrow_decoder;

   typedef struct {
      bit         is_err;
      logic [7:0] code;
      logic       mb;
      logic [3:0] dir;
   } ev_t;

`ifdef PS2_TIMEOUT_EN
   localparam int SLOW_HALF = 40;
`else
   localparam int SLOW_HALF = 200;
`endif
   localparam int FAST_HALF = 32;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic       up, down, left, right;
   logic [7:0] scan_code;
   logic       make_break, code_valid, frame_err;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_valid  = 0;
   int   n_ferr   = 0;
   int   cyc      = 0;
   int   fall_cyc = 0;
   int   last_err_cyc = 0;
   ev_t  q[$];
   logic [3:0] m_dir = 4'b0000;
   logic [3:0] s_dir = 4'b0000;
   bit   s_ext = 1'b0;
   bit   s_brk = 1'b0;

   ps2_arrow_decoder #(.TIMEOUT_CYCLES(100)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .PS2_CLK    (PS2_CLK),
      .PS2_DAT    (PS2_DAT),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .scan_code  (scan_code),
      .make_break (make_break),
      .code_valid (code_valid),
      .frame_err  (frame_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] key_dir(input logic [7:0] b);
      case (b)
         8'h75:   return 4'b1000;
         8'h72:   return 4'b0100;
         8'h6B:   return 4'b0010;
         8'h74:   return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Comparator: every event the model queued must appear as exactly one pulse.
   always @(negedge CLOCK_50) begin
      ev_t ev;
      if (!reset_n) begin
         check("reset_outputs", {up, down, left, right, scan_code, make_break, code_valid, frame_err}, 0);
         m_dir = 4'b0000;
      end else begin
         if (code_valid) begin
            n_valid++;
            check("code_valid_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               ev = q.pop_front();
               check("event_is_key", ev.is_err, 0);
               check("scan_code", scan_code, ev.code);
               check("make_break", make_break, ev.mb);
               m_dir = ev.dir;
            end
         end
         if (frame_err) begin
            n_ferr++;
            last_err_cyc = cyc;
            check("frame_err_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               ev = q.pop_front();
               check("event_is_err", ev.is_err, 1);
            end
         end
         check("directions", {up, down, left, right}, m_dir);
      end
   end

   task automatic drive_bits(input logic [10:0] bits, input int nbits, input int half);
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = bits[i];
         repeat (half) @(posedge CLOCK_50);
         PS2_CLK  = 1'b0;
         fall_cyc = cyc;
         repeat (half) @(posedge CLOCK_50);
         PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit good, input int half);
      logic       par;
      logic [3:0] kd;
      ev_t        ev;
      par = good ? ~(^b) : (^b);
      if (!good) begin
         ev = '{is_err: 1'b1, code: 8'h00, mb: 1'b0, dir: s_dir};
         q.push_back(ev);
         s_ext = 1'b0;
         s_brk = 1'b0;
      end else if (b == 8'hE0) begin
         s_ext = 1'b1;
      end else if (b == 8'hF0) begin
         s_brk = 1'b1;
      end else begin
         kd = s_ext ? key_dir(b) : 4'b0000;
         if (kd != 4'b0000) begin
            if (!s_brk)           s_dir = kd;
            else if (s_dir == kd) s_dir = 4'b0000;
         end
         ev = '{is_err: 1'b0, code: b, mb: ~s_brk, dir: s_dir};
         q.push_back(ev);
         s_ext = 1'b0;
         s_brk = 1'b0;
      end
      drive_bits({1'b1, par, b, 1'b0}, 11, half);
      repeat (2 * half) @(posedge CLOCK_50);
   endtask

   initial begin
      int v0;
      int f0;
      reset_n = 1'b0;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      repeat (5) @(posedge CLOCK_50);
      reset_n = 1'b1;
      repeat (5) @(posedge CLOCK_50);

      // Extended up make at the slow bus rate
      v0 = n_valid;
      send_byte(8'hE0, 1'b1, SLOW_HALF);
      send_byte(8'h75, 1'b1, SLOW_HALF);
      check("t1_valid_count", n_valid - v0, 1);
      check("t1_scan", scan_code, 8'h75);
      check("t1_make", make_break, 1'b1);
      check("t1_dirs", {up, down, left, right}, 4'b1000);

      // Last pressed wins; stale break ignored; matching break releases
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'h6B, 1'b1, FAST_HALF);
      check("t2_left_over_up", {up, down, left, right}, 4'b0010);
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'hF0, 1'b1, FAST_HALF);
      send_byte(8'h75, 1'b1, FAST_HALF);
      check("t2_up_break_ignored", {up, down, left, right}, 4'b0010);
      check("t2_break_flag", make_break, 1'b0);
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'hF0, 1'b1, FAST_HALF);
      send_byte(8'h6B, 1'b1, FAST_HALF);
      check("t2_left_released", {up, down, left, right}, 4'b0000);

      // Keypad 0x72 without prefix reports but does not steer
      send_byte(8'h72, 1'b1, FAST_HALF);
      check("t3_scan", scan_code, 8'h72);
      check("t3_make", make_break, 1'b1);
      check("t3_down_stays_0", {up, down, left, right}, 4'b0000);

      // Non-arrow break
      send_byte(8'hF0, 1'b1, FAST_HALF);
      send_byte(8'h1C, 1'b1, FAST_HALF);
      check("t4_scan", scan_code, 8'h1C);
      check("t4_break", make_break, 1'b0);

      // Bad parity frame with down held
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'h72, 1'b1, FAST_HALF);
      check("t5_down", {up, down, left, right}, 4'b0100);
      v0 = n_valid;
      f0 = n_ferr;
      send_byte(8'h1C, 1'b0, FAST_HALF);
      check("t5_ferr_count", n_ferr - f0, 1);
      check("t5_no_valid", n_valid - v0, 0);
      check("t5_dirs_held", {up, down, left, right}, 4'b0100);
      check("t5_scan_held", scan_code, 8'h72);

      // Reset after 5 data bits, then complete frames
      drive_bits({1'b1, 1'b0, 8'hE0, 1'b0}, 6, FAST_HALF);
      reset_n = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      q.delete();
      s_dir = 4'b0000;
      s_ext = 1'b0;
      s_brk = 1'b0;
      reset_n = 1'b1;
      repeat (5) @(posedge CLOCK_50);
      check("t6_dirs_after_reset", {up, down, left, right}, 4'b0000);
      v0 = n_valid;
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'h74, 1'b1, FAST_HALF);
      check("t6_valid_count", n_valid - v0, 1);
      check("t6_right", {up, down, left, right}, 4'b0001);

      // Rejected frame also drops a pending E0 prefix
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'h1C, 1'b0, FAST_HALF);
      send_byte(8'h6B, 1'b1, FAST_HALF);
      check("t7_ext_dropped", {up, down, left, right}, 4'b0001);
      check("t7_scan", scan_code, 8'h6B);

`ifdef PS2_TIMEOUT_EN
      // Bus stalls after 3 bits; watchdog must fire once, then recover
      f0 = n_ferr;
      begin
         ev_t ev;
         ev = '{is_err: 1'b1, code: 8'h00, mb: 1'b0, dir: s_dir};
         q.push_back(ev);
         s_ext = 1'b0;
         s_brk = 1'b0;
      end
      drive_bits({1'b1, 1'b0, 8'h00, 1'b0}, 3, FAST_HALF);
      repeat (200) @(posedge CLOCK_50);
      check("t8_ferr_count", n_ferr - f0, 1);
      check("t8_latency_in_window",
            (last_err_cyc - fall_cyc >= 99) && (last_err_cyc - fall_cyc <= 106), 1);
      send_byte(8'hE0, 1'b1, FAST_HALF);
      send_byte(8'h6B, 1'b1, FAST_HALF);
      check("t8_recovered_left", {up, down, left, right}, 4'b0010);
`endif

      check("pending_events", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
